// File: rtl/vbs_capture.sv
// ----------------------------------------------------------------------------
// vbs_capture
//
// Receiving end of the two-wire (sync, pixel) composite video link. Recovers
// line and frame timing from the sync pulses, samples the 1-bit pixel stream
// inside the active window and re-packs it MSB-first into bytes tagged with
// their x (byte within line) and y (active line) coordinates.
//
// Ports
//   clk         system clock (8 MHz nominal)
//   reset       synchronous, active-high
//   sync        composite sync, low = pulse, already in the clk domain
//   pixel       video bit, 1 = white
//   data        captured byte, first pixel of the byte in bit 7
//   data_valid  one-cycle strobe qualifying data/x/y
//   x           byte index within the active line
//   y           active line index
//   frame_done  one-cycle pulse alongside the last byte of a frame
//   locked      high while frame timing is valid
//
// Pipeline: pin -> input regs -> shift register / byte-done flag -> output
// regs, so a byte strobes 3 clocks after its 8th pixel reaches the pin.
// ----------------------------------------------------------------------------
module vbs_capture #(
    parameter int LINE_CLOCKS   = 512,
    parameter int VSYNC_MIN     = 256,
    parameter int H_START       = 95,
    parameter int ACTIVE_PIXELS = 320,
    parameter int V_START       = 31,
    parameter int ACTIVE_LINES  = 192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sync,
    input  logic       pixel,
    output logic [7:0] data,
    output logic       data_valid,
    output logic [5:0] x,
    output logic [7:0] y,
    output logic       frame_done,
    output logic       locked
);

    // ------------------------------------------------------------------
    // Timing constants, sized to the counters they are compared against
    // ------------------------------------------------------------------
    localparam logic [9:0] HC_MAX    = 10'd1023;
    localparam logic [9:0] LOW_MAX   = 10'd1023;
    localparam logic [8:0] LINE_MAX  = 9'd511;
    localparam logic [9:0] HC_LOSS   = 10'(LINE_CLOCKS + 16);
    localparam logic [9:0] LOW_BROAD = 10'(VSYNC_MIN);
    localparam logic [9:0] H_FIRST   = 10'(H_START);
    localparam logic [9:0] H_PRE     = 10'(H_START - 1);
    localparam logic [9:0] H_END     = 10'(H_START + ACTIVE_PIXELS);
    localparam logic [8:0] V_FIRST   = 9'(V_START);
    localparam logic [8:0] V_END     = 9'(V_START + ACTIVE_LINES);
    localparam logic [5:0] X_LAST    = 6'(ACTIVE_PIXELS / 8 - 1);
    localparam logic [7:0] Y_LAST    = 8'(ACTIVE_LINES - 1);

    // Coordinates of a byte travelling from the shift stage to the outputs
    typedef struct packed {
        logic [5:0] bx;
        logic [7:0] by;
    } byte_pos_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // input stage
    logic       sync_q,   sync_d;
    logic       sync_p_q, sync_p_d;
    logic       pixel_q,  pixel_d;
    // timing recovery
    logic [9:0] hcount_q,  hcount_d;
    logic [9:0] low_cnt_q, low_cnt_d;
    logic [8:0] line_q,    line_d;
    logic       broad_q,   broad_d;
    logic       locked_q,  locked_d;
    // pixel packing
    logic [7:0] sr_q,      sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       done_q,    done_d;
    byte_pos_t  pos_q,     pos_d;
    // registered outputs
    logic [7:0] data_q,       data_d;
    logic       data_valid_q, data_valid_d;
    logic [5:0] x_q,          x_d;
    logic [7:0] y_q,          y_d;
    logic       frame_done_q, frame_done_d;

    // Edge detect on the registered sync
    logic fall, rise;
    logic lock_loss;
    logic h_act, v_act, act;

    assign fall = sync_p_q & ~sync_q;
    assign rise = ~sync_p_q & sync_q;

    // A line that runs well past nominal length without a fall means the
    // sync source has gone away; hcount saturates, so this holds until a fall.
    assign lock_loss = ~fall & (hcount_q >= HC_LOSS);

    assign h_act = (hcount_q >= H_FIRST) & (hcount_q < H_END);
    assign v_act = (line_q >= V_FIRST) & (line_q < V_END);
    assign act   = locked_q & v_act & h_act;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        sync_d       = sync;
        sync_p_d     = sync_q;
        pixel_d      = pixel;
        hcount_d     = hcount_q;
        low_cnt_d    = low_cnt_q;
        line_d       = line_q;
        broad_d      = broad_q;
        locked_d     = locked_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        done_d       = 1'b0;
        pos_d        = pos_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        frame_done_d = 1'b0;

        // Horizontal position since the last fall, saturating
        if (fall) begin
            hcount_d = 10'd0;
        end else if (hcount_q != HC_MAX) begin
            hcount_d = hcount_q + 10'd1;
        end

        // Sync-low width. The fall cycle is itself a low cycle, so it
        // restarts the count at 1: a 1-clock pulse measures 1 at its rise.
        if (fall) begin
            low_cnt_d = 10'd1;
        end else if (!sync_q && low_cnt_q != LOW_MAX) begin
            low_cnt_d = low_cnt_q + 10'd1;
        end

        // Losing lock also forgets any broad pulse seen before the dropout,
        // so only a fresh broad pulse followed by a fall re-locks.
        if (lock_loss) begin
            locked_d = 1'b0;
            broad_d  = 1'b0;
        end

        if (rise && low_cnt_q >= LOW_BROAD) begin
            broad_d = 1'b1;
        end

        // Each fall opens a new line. The fall following the last broad
        // pulse of the vertical group is the one that leaves line at 0.
        if (fall) begin
            if (broad_q) begin
                line_d   = 9'd0;
                broad_d  = 1'b0;
                locked_d = 1'b1;
            end else if (line_q != LINE_MAX) begin
                line_d = line_q + 9'd1;
            end
        end

        // Bit counter realigns just before the window; a fall anywhere
        // (including mid-window) also discards any partial byte.
        if (fall || hcount_q == H_PRE) begin
            bit_cnt_d = 3'd0;
        end else if (act) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        if (act) begin
            sr_d = {sr_q[6:0], pixel_q};
            if (bit_cnt_q == 3'd7) begin
                done_d   = 1'b1;
                pos_d.bx = 6'((hcount_q - H_FIRST) >> 3);
                pos_d.by = 8'(line_q - V_FIRST);
            end
        end

        // Output stage: sr_q now holds the full byte
        if (done_q) begin
            data_valid_d = 1'b1;
            data_d       = sr_q;
            x_d          = pos_q.bx;
            y_d          = pos_q.by;
            frame_done_d = (pos_q.bx == X_LAST) && (pos_q.by == Y_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= 1'b1;
            sync_p_q     <= 1'b1;
            pixel_q      <= 1'b0;
            hcount_q     <= 10'd0;
            low_cnt_q    <= 10'd0;
            line_q       <= 9'd0;
            broad_q      <= 1'b0;
            locked_q     <= 1'b0;
            sr_q         <= 8'd0;
            bit_cnt_q    <= 3'd0;
            done_q       <= 1'b0;
            pos_q        <= '0;
            data_q       <= 8'd0;
            data_valid_q <= 1'b0;
            x_q          <= 6'd0;
            y_q          <= 8'd0;
            frame_done_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            sync_p_q     <= sync_p_d;
            pixel_q      <= pixel_d;
            hcount_q     <= hcount_d;
            low_cnt_q    <= low_cnt_d;
            line_q       <= line_d;
            broad_q      <= broad_d;
            locked_q     <= locked_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            done_q       <= done_d;
            pos_q        <= pos_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign x          = x_q;
    assign y          = y_q;
    assign frame_done = frame_done_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_vbs_capture.sv
// Bench for vbs_capture, run with scaled-down timing so whole frames fit.
// A timestamp-based reference model predicts every output cycle by cycle.
module tb_vbs_capture;

    localparam int LC    = 128;  // clocks per line
    localparam int VMIN  = 64;   // broad-pulse threshold
    localparam int HS    = 20;
    localparam int AP    = 64;   // 8 bytes per line
    localparam int VS    = 5;
    localparam int AL    = 8;
    localparam int NNORM = 16;   // normal lines per frame
    localparam int BLOW  = 100;  // broad-line sync-low width

    logic       clk, reset, sync, pixel;
    logic [7:0] data;
    logic       data_valid, frame_done, locked;
    logic [5:0] x;
    logic [7:0] y;

    vbs_capture #(
        .LINE_CLOCKS(LC), .VSYNC_MIN(VMIN), .H_START(HS),
        .ACTIVE_PIXELS(AP), .V_START(VS), .ACTIVE_LINES(AL)
    ) dut (
        .clk(clk), .reset(reset), .sync(sync), .pixel(pixel),
        .data(data), .data_valid(data_valid), .x(x), .y(y),
        .frame_done(frame_done), .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Time is counted in clock edges; cycle k is the
    // interval after edge k. Pin values sampled at edge k are the
    // registered sync/pixel seen during cycle k.
    // ------------------------------------------------------------------
    int         cur = 0;
    bit         model_ok = 0;
    bit         m_sq, m_sp;
    int         t_hc0;     // cycle at which hcount was 0
    int         t_fall;    // cycle of the most recent fall
    int         m_line;
    bit         m_locked, m_broad;
    logic [7:0] pbuf;
    // expected outputs per cycle, slot = cycle % 4
    bit         e_dv[4], e_fd[4], e_rst[4], e_lk[4];
    logic [7:0] e_data[4];
    int         e_x[4], e_y[4];
    // observation counters
    int         n_strobe, n_nz, n_fd;
    int         nz_x, nz_y;
    logic [7:0] nz_data;

    task automatic clear_counts();
        n_strobe = 0; n_nz = 0; n_fd = 0;
        nz_x = -1; nz_y = -1; nz_data = 8'h00;
    endtask

    task automatic model_edge(input bit s, input bit p, input bit r);
        int k, sl, s2, hc, bx, by;
        bit fl, rs;
        k = cur + 1;
        cur = k;
        sl = k % 4;
        pbuf = {pbuf[6:0], p};
        if (r) begin
            m_sq = 1; m_sp = 1; t_hc0 = k; t_fall = k;
            m_line = 0; m_locked = 0; m_broad = 0;
            e_rst[sl] = 1; e_dv[sl] = 0; e_fd[sl] = 0; e_lk[sl] = 0;
            e_dv[(k + 1) % 4] = 0; e_fd[(k + 1) % 4] = 0;
            model_ok = 1;
            return;
        end
        m_sp = m_sq;
        m_sq = s;
        fl = m_sp && !m_sq;
        rs = !m_sp && m_sq;
        hc = k - t_hc0;
        if (hc > 1023) hc = 1023;
        e_lk[sl] = m_locked;
        // A byte completes on the pixel at window offset 8n+7
        if (m_locked && m_line >= VS && m_line < VS + AL &&
            hc >= HS && hc < HS + AP && (hc - HS) % 8 == 7) begin
            s2 = (k + 2) % 4;
            bx = (hc - HS) / 8;
            by = m_line - VS;
            e_dv[s2] = 1; e_data[s2] = pbuf; e_x[s2] = bx; e_y[s2] = by;
            e_fd[s2] = (bx == AP / 8 - 1) && (by == AL - 1);
        end
        if (!fl && hc >= LC + 16) begin
            m_locked = 0; m_broad = 0;
        end
        if (rs && (k - t_fall) >= VMIN) m_broad = 1;
        if (fl) begin
            t_fall = k;
            t_hc0 = k + 1;
            if (m_broad) begin
                m_line = 0; m_broad = 0; m_locked = 1;
            end else if (m_line < 511) begin
                m_line++;
            end
        end
    endtask

    task automatic check_cycle();
        int sl;
        if (!model_ok) return;
        sl = cur % 4;
        chk("locked", 32'(locked), 32'(e_lk[sl]));
        chk("data_valid", 32'(data_valid), 32'(e_dv[sl]));
        chk("frame_done", 32'(frame_done), 32'(e_fd[sl]));
        if (e_dv[sl] || e_rst[sl]) begin
            chk("data", 32'(data), e_rst[sl] ? 32'd0 : 32'(e_data[sl]));
            chk("x", 32'(x), e_rst[sl] ? 32'd0 : 32'(e_x[sl]));
            chk("y", 32'(y), e_rst[sl] ? 32'd0 : 32'(e_y[sl]));
        end
        if (data_valid === 1'b1) begin
            n_strobe++;
            if (data != 8'h00) begin
                n_nz++; nz_data = data; nz_x = int'(x); nz_y = int'(y);
            end
        end
        if (frame_done === 1'b1) n_fd++;
        e_dv[sl] = 0; e_fd[sl] = 0; e_rst[sl] = 0;
    endtask

    // One clock: check the cycle just finished, then drive the next pins
    task automatic step(input bit s, input bit p, input bit r);
        @(negedge clk);
        check_cycle();
        sync = s; pixel = p; reset = r;
        model_edge(s, p, r);
    endtask

    // ptype: 0 black, 1 first bit of each byte, 2 random, 3 A5 at byte 5
    task automatic drive_line(input int low, input int ptype, input int extra_at, input int rst_at);
        logic [7:0] pat;
        bit s, p;
        int h;
        pat = 8'hA5;
        for (int i = 0; i < LC; i++) begin
            s = (i >= low);
            if (extra_at >= 0 && i >= extra_at && i < extra_at + 3) s = 0;
            h = i - 1;  // hcount at which this pin value is shifted in
            p = 0;
            if (ptype == 2) p = bit'($urandom_range(0, 1));
            else if (h >= HS && h < HS + AP) begin
                if (ptype == 1) p = ((h - HS) % 8 == 0);
                if (ptype == 3 && (h - HS) / 8 == 5) p = pat[7 - (h - HS) % 8];
            end
            step(s, p, i == rst_at);
        end
    endtask

    task automatic drive_frame(input int ptype, input int broad_low, input int n_norm,
                               input int sp_idx, input int sp_extra, input int sp_rst);
        int pt, lw;
        for (int b = 0; b < 3; b++) drive_line(broad_low, 0, -1, -1);
        for (int n = 0; n < n_norm; n++) begin
            pt = ptype;
            if (ptype == 3 && n != VS) pt = 0;
            lw = (ptype == 2) ? int'($urandom_range(1, 30)) : 8;
            drive_line(lw, pt, (n == sp_idx) ? sp_extra : -1, (n == sp_idx) ? sp_rst : -1);
        end
    endtask

    task automatic hold_high(input int n);
        for (int i = 0; i < n; i++) step(1, bit'($urandom_range(0, 1)), 0);
    endtask

    initial begin
        sync = 1'b1; pixel = 1'b0; reset = 1'b1;
        pbuf = 8'h00;
        for (int i = 0; i < 4; i++) begin
            e_dv[i] = 0; e_fd[i] = 0; e_rst[i] = 0; e_lk[i] = 0;
            e_data[i] = 8'h00; e_x[i] = 0; e_y[i] = 0;
        end
        clear_counts();
        repeat (3) step(1, 0, 1);

        // Normal lines only: never locks
        clear_counts();
        repeat (12) drive_line(8, 2, -1, -1);
        chk("nolock_strobes", n_strobe, 0);
        chk("nolock_locked", 32'(locked), 0);

        // First pixel of every byte white
        clear_counts();
        drive_frame(1, BLOW, NNORM, -1, -1, -1);
        chk("fb_strobes", n_strobe, AP / 8 * AL);
        chk("fb_nonzero", n_nz, AP / 8 * AL);
        chk("fb_frames", n_fd, 1);

        // Single A5 byte at x=5, y=0
        clear_counts();
        drive_frame(3, BLOW, NNORM, -1, -1, -1);
        chk("a5_count", n_nz, 1);
        chk("a5_data", 32'(nz_data), 32'h A5);
        chk("a5_x", nz_x, 5);
        chk("a5_y", nz_y, 0);

        // Sync disappears mid-frame: lock drops, nothing captured until re-lock
        drive_frame(2, BLOW, 7, -1, -1, -1);
        clear_counts();
        hold_high(200);
        repeat (4) drive_line(8, 1, -1, -1);
        chk("loss_strobes", n_strobe, 0);
        chk("loss_locked", 32'(locked), 0);
        clear_counts();
        drive_frame(1, BLOW, NNORM, -1, -1, -1);
        chk("relock_strobes", n_strobe, AP / 8 * AL);

        // Reset mid-byte (byte 1) on active line 2: rest of frame dropped
        clear_counts();
        drive_frame(1, BLOW, NNORM, VS + 2, -1, 33);
        chk("rst_strobes", n_strobe, 2 * AP / 8 + 1);
        chk("rst_frames", n_fd, 0);
        clear_counts();
        drive_frame(1, BLOW, NNORM, -1, -1, -1);
        chk("rst_recap", n_strobe, AP / 8 * AL);

        // Extra fall at pin 50 of active line 3: 3 bytes, then a 7-byte
        // fragment counted as the next line, then lines shifted by one
        clear_counts();
        drive_frame(1, BLOW, NNORM, VS + 3, 50, -1);
        chk("extra_strobes", n_strobe, 58);
        chk("extra_frames", n_fd, 1);

        // Broad threshold: VMIN-1 does not lock, VMIN does
        hold_high(200);
        clear_counts();
        drive_frame(1, VMIN - 1, NNORM, -1, -1, -1);
        chk("narrow_strobes", n_strobe, 0);
        chk("narrow_locked", 32'(locked), 0);
        clear_counts();
        drive_frame(1, VMIN, NNORM, -1, -1, -1);
        chk("thresh_strobes", n_strobe, AP / 8 * AL);

        // Random frames: random pixels, sync widths (down to 1) and extra falls
        for (int f = 0; f < 4; f++) begin
            drive_frame(2, int'($urandom_range(VMIN, 120)), NNORM,
                        int'($urandom_range(0, NNORM - 1)), int'($urandom_range(40, 110)), -1);
        end
        hold_high(4);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/vbs_capture.md
Name: vbs_capture

Overview:
- Composite-video capture/decoder, the receiving end of our 8 MHz two-wire video output (sync, pixel).
- Recovers line and frame timing from the sync pulses and samples the 1-bit pixel stream inside the active window.
- Re-packs pixels MSB-first into bytes and emits them with x/y coordinates.
- Used as a self-checking sink in benches and as a loopback checker on hardware.

Parameters:
- LINE_CLOCKS, 512, nominal clocks per line; also sets the lock-loss timeout.
- VSYNC_MIN, 256, minimum sync-low width in clocks that classifies a pulse as broad (vertical).
- H_START, 95, hcount value of the first active pixel sample.
- ACTIVE_PIXELS, 320, active pixels per line; must be a multiple of 8.
- V_START, 31, line number of the first active line.
- ACTIVE_LINES, 192, number of active lines.

Ports:
- clk  in  1  system clock, 8 MHz
- reset  in  1  synchronous, active-high
- sync  in  1  composite sync, low = pulse; same clock domain
- pixel  in  1  video bit, 1 = white
- data  out  8  captured byte; the first pixel of the byte is in bit 7
- data_valid  out  1  one-cycle strobe; data/x/y are valid while it is high
- x  out  6  byte index within the line, 0..ACTIVE_PIXELS/8-1
- y  out  8  active line index, 0..ACTIVE_LINES-1
- frame_done  out  1  one-cycle pulse after the last byte of a frame
- locked  out  1  high while frame timing is valid

Behaviour:
- Input stage:
  - sync_q and pixel_q are registered copies of the inputs; sync_p is the previous sync_q.
  - fall = sync_p & ~sync_q; rise = ~sync_p & sync_q.
  - All timing below is relative to the registered signals.
- Reset:
  - Sets data=0, data_valid=0, x=0, y=0, frame_done=0, locked=0.
  - Clears hcount, line, low_cnt, broad_flag and shift register.
  - sync_q and sync_p reset to 1.
  - Reset mid-byte discards the partial byte, with no strobe.
- hcount (10 bit):
  - Set to 0 on a fall cycle; otherwise increments, saturating at 1023.
- low_cnt (10 bit):
  - Cleared on fall; increments, saturating, while sync_q = 0.
  - On rise: if low_cnt >= VSYNC_MIN, broad_flag is set (classification only, no other effect).
- line (9 bit), updated on each fall:
  - If broad_flag: line <= 0, broad_flag <= 0, locked <= 1.
  - Otherwise line <= line + 1, saturating at 511.
  - Only the fall after the last broad pulse of a vertical group leaves line = 0.
- Lock loss:
  - When hcount reaches LINE_CLOCKS + 16 with no fall, locked <= 0.
  - Capture is suppressed until the next broad pulse re-locks.
- Active window:
  - act = locked & (V_START <= line < V_START + ACTIVE_LINES) & (H_START <= hcount < H_START + ACTIVE_PIXELS).
  - Each act cycle shifts pixel_q into the LSB of an 8-bit shift register.
  - A 3-bit bit counter is cleared at hcount = H_START - 1.
- Byte output:
  - The cycle after the 8th bit is shifted: data = completed byte, data_valid = 1 for one cycle.
  - x = (hcount - H_START) >> 3 of the 8th bit; y = line - V_START.
- frame_done:
  - Asserted in the same cycle as data_valid for x = ACTIVE_PIXELS/8-1, y = ACTIVE_LINES-1.
- Boundary conditions:
  - A fall inside the active window: the current line aborts, the partial byte is dropped, and a new line starts (hcount = 0).
  - Broad pulse followed by lock loss: locked = 0 takes priority until the next broad-then-fall sequence.
  - fall and rise cannot occur in the same cycle; a pulse of 1 clock gives low_cnt = 1, which is not broad.
- Latency: pixel input to data_valid is 1 (input reg) + 1 (shift) + 1 (output reg) = 3 clocks after the 8th pixel appears on the pin.

Test Plan:
- Drive 313-line frames of 512 clocks each: 3 broad lines, then normal lines with sync low 29 clocks at line start; pixel = 1 only for the first bit of each byte → 40 × 192 strobes per frame, all data = 8'h80, x wraps 0..39, y 0..191, one frame_done.
- Pixel pattern 8'hA5 at byte x=5, y=0, all else 0 → exactly one nonzero byte: data = 8'hA5, x = 5, y = 0, 3 clocks after its last pixel.
- Before the first broad pulse, normal lines only → locked = 0 and zero data_valid strobes.
- Remove sync for 600 clocks mid-frame → locked drops at hcount 528; no strobes until the next broad pulse plus fall; captures then resume with y = 0.
- Assert reset for 1 cycle mid-byte at line V_START+10 → all outputs 0 next cycle; no strobe for the partial byte; recapture only after the next frame sync.
- Extra sync fall at hcount 200 of an active line → that line's remaining bytes are not emitted; line increments; subsequent lines' y is offset by +1.
